hiscore_uploader: RTL and testbench
===================================

HISCORE_UPLOADER -- requirements
Module: hiscore_uploader

Interface
REQ-001 Parameter BASE, default 11'h000: first game-RAM byte of the saved region.
REQ-002 Parameter LEN, default 12'd64: region length in bytes, 1..2048.
REQ-003 Parameter INDEX, default 8'd4: ioctl_index value this block answers to.
REQ-004 Port clk_sys, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port ioctl_upload, input, 1: HPS upload session active (level).
REQ-007 Port ioctl_index, input, 8: session index.
REQ-008 Port ioctl_rd, input, 1: one-cycle byte request strobe.
REQ-009 Port ioctl_addr, input, 25: requested byte offset.
REQ-010 Port ioctl_din, output, 8: returned byte.
REQ-011 Port ioctl_wait, output, 1: HPS must not sample ioctl_din or issue ioctl_rd while high.
REQ-012 Port vblank, input, 1: game vertical blank.
REQ-013 Port cpu_pause, output, 1: halts the game CPU while high.
REQ-014 Port ram_addr, output, 11: game-RAM read address.
REQ-015 Port ram_rd, output, 1: game-RAM read enable; data returns after 1 cycle.
REQ-016 Port ram_data, input, 8: game-RAM read data.
REQ-017 Port done, output, 1: one-cycle pulse when the last region byte (offset LEN-1) is delivered.

Function
REQ-018 The FSM SHALL use states IDLE, SYNC, READY, ISSUE, CAPTURE.
- IDLE->SYNC: rising edge of ioctl_upload with ioctl_index==INDEX.
- SYNC->READY: first cycle vblank==1.
- READY->ISSUE: pending request.
- ISSUE->CAPTURE: always.
- CAPTURE->READY: always.
REQ-019 cpu_pause SHALL be 1 in every state except IDLE.
REQ-020 ioctl_rd SHALL be latched as a pending request, with its address, in any non-IDLE state; in IDLE it SHALL be ignored.
REQ-021 ioctl_wait SHALL go high the cycle after ioctl_rd is sampled and stay high until the data is in ioctl_din.
REQ-022 In ISSUE with offset<LEN: ram_rd=1 and ram_addr=(BASE+offset[10:0]) mod 2048; ram_rd SHALL be 0 in all other states.
REQ-023 In CAPTURE: ioctl_din<=ram_data, or 8'hFF if offset>=LEN; ioctl_wait<=0.
- Minimum request-to-data latency from READY: 3 cycles.
REQ-024 A request issued during SYNC SHALL stay pending, with ioctl_wait held high, until SYNC exits.
REQ-025 ioctl_rd arriving while a request is pending or in flight SHALL be dropped (protocol violation) and SHALL NOT corrupt the pending request.
REQ-026 done SHALL pulse in CAPTURE when offset==LEN-1.
REQ-027 Falling ioctl_upload in any state SHALL abort within one cycle:
- enter IDLE
- clear the pending request
- cpu_pause=0, ioctl_wait=0
- ioctl_din keeps its value.
REQ-028 ioctl_addr bits above 11 SHALL only participate in the offset>=LEN compare.

Reset
REQ-029 Reset SHALL force IDLE, ioctl_din=8'h00, ioctl_wait=0, cpu_pause=0, ram_rd=0, ram_addr=0, done=0, and clear the pending request and the upload edge detector.

Structure
REQ-030 The FSM state enum and the 8'hFF fill constant SHALL be in the shared package.
REQ-031 No sub-module SHALL be used; the block is a single FSM with request latch.

Verification
REQ-032 Reset release with ioctl_upload=0 -> all outputs zero; ioctl_rd pulses are ignored.
REQ-033 Upload with INDEX=4 while vblank=0 for 100 cycles, ioctl_rd at addr 0 -> ioctl_wait high throughout; after vblank rises, ram_addr=BASE; ioctl_din=RAM[BASE]; ioctl_wait falls.
REQ-034 BASE=11'h7F0, LEN=32, read offsets 0..31 -> ram_addr wraps 7F0..7FF then 000..00F; done pulses exactly once, on offset 31.
REQ-035 Read offset 40 with LEN=32 -> ram_rd stays 0; ioctl_din=8'hFF.
REQ-036 ioctl_upload drops during ISSUE -> next cycle IDLE, cpu_pause=0, ioctl_wait=0, no done pulse.
REQ-037 Upload with ioctl_index=3 -> stays IDLE; cpu_pause=0; reads ignored.

Source files
------------

// File: rtl/hiscore_uploader_pkg.sv
// Shared types and constants for the high-score upload engine.
package hiscore_uploader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_READY,
        ST_ISSUE,
        ST_CAPTURE
    } state_e;

    localparam int          OFS_W     = 25;
    localparam logic [7:0]  FILL_BYTE = 8'hFF;

endpackage

// File: rtl/hiscore_uploader.sv
// Serves HPS upload reads of a game-RAM window, pausing the CPU and
// aligning the first access to vertical blank.
module hiscore_uploader
    import hiscore_uploader_pkg::*;
#(
    parameter logic [10:0] BASE  = 11'h000,
    parameter logic [11:0] LEN   = 12'd64,
    parameter logic [7:0]  INDEX = 8'd4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [OFS_W-1:0]  ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic              vblank,
    output logic              cpu_pause,
    output logic [10:0]       ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic              done
);

    state_e             state_q, state_d;
    logic               upload_q;
    logic               pending_q, pending_d;
    logic [OFS_W-1:0]   offset_q, offset_d;
    logic [7:0]         din_q, din_d;
    logic               wait_q, wait_d;

    logic               start_up;
    logic               in_range;
    logic               is_last;

    assign start_up = ioctl_upload && !upload_q && (ioctl_index == INDEX);
    // Upper offset bits only matter for the range test, never for the RAM address.
    assign in_range = offset_q < OFS_W'(LEN);
    assign is_last  = offset_q == (OFS_W'(LEN) - OFS_W'(1));

    // NOTE: every _d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        offset_d  = offset_q;
        din_d     = din_q;
        wait_d    = wait_q;

        case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;
                wait_d    = 1'b0;
                if (start_up) state_d = ST_SYNC;
            end
            ST_SYNC:    if (vblank) state_d = ST_READY;
            ST_READY:   if (pending_q) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                din_d     = in_range ? ram_data : FILL_BYTE;
                wait_d    = 1'b0;
                pending_d = 1'b0;
                state_d   = ST_READY;
            end
            default:    state_d = ST_IDLE;
        endcase

        // A strobe while a request is pending or in flight is dropped untouched.
        if (state_q != ST_IDLE && ioctl_rd && !pending_q) begin
            pending_d = 1'b1;
            offset_d  = ioctl_addr;
            wait_d    = 1'b1;
        end

        if (state_q != ST_IDLE && !ioctl_upload) begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
            wait_d    = 1'b0;
            din_d     = din_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            upload_q  <= 1'b0;
            pending_q <= 1'b0;
            offset_q  <= '0;
            din_q     <= 8'h00;
            wait_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            upload_q  <= ioctl_upload;
            pending_q <= pending_d;
            offset_q  <= offset_d;
            din_q     <= din_d;
            wait_q    <= wait_d;
        end
    end

    assign cpu_pause  = state_q != ST_IDLE;
    assign ram_rd     = (state_q == ST_ISSUE) && in_range && ioctl_upload;
    assign ram_addr   = ram_rd ? (BASE + offset_q[10:0]) : 11'h000;
    assign done       = (state_q == ST_CAPTURE) && ioctl_upload && is_last;
    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;

endmodule

// File: tb/tb_hiscore_uploader.sv
// Scoreboard bench for hiscore_uploader: stimulus queues expected RAM
// addresses and bytes, a negedge monitor compares them as the DUT delivers.
module tb_hiscore_uploader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        vblank;
    logic        cpu_pause;
    logic [10:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_data;
    logic        done;

    hiscore_uploader #(
        .BASE  (11'h7F0),
        .LEN   (12'd32),
        .INDEX (8'd4)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .vblank       (vblank),
        .cpu_pause    (cpu_pause),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_data     (ram_data),
        .done         (done)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [7:0] din;
        logic       done;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] addr_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          done_count = 0;
    logic        done_seen = 1'b0;
    logic        prev_wait = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [10:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk_sys) if (ram_rd) ram_data <= mem_byte(ram_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (done) begin
                done_seen = 1'b1;
                done_count++;
            end
            if (ram_rd) begin
                if (addr_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected ram_rd: addr %0h, expected no read", ram_addr);
                end else begin
                    logic [10:0] ea;
                    ea = addr_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(ea));
                end
            end
            if (prev_wait && !ioctl_wait && ioctl_upload) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected delivery: din %0h, expected none", ioctl_din);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ioctl_din", 32'(ioctl_din), 32'(e.din));
                    check("done on delivery", 32'(done_seen), 32'(e.done));
                end
                done_seen = 1'b0;
            end
            prev_wait = ioctl_wait;
        end
    end

    task automatic do_read(input logic [24:0] a);
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_delivery(input string name);
        int k = 0;
        while (ioctl_wait && k < 200) begin
            @(negedge clk_sys);
            k++;
        end
        check({name, " wait released"}, 32'(ioctl_wait), 32'h0);
    endtask

    task automatic expect_byte(input int ofs, input logic is_done);
        logic [10:0] ea;
        exp_t        e;
        ea = 11'h7F0 + 11'(ofs);
        addr_q.push_back(ea);
        e.din  = mem_byte(ea);
        e.done = is_done;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   lows;
        int   k;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd4;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        vblank       = 1'b0;
        ram_data     = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;

        // Reset state; reads with no upload session are ignored.
        @(negedge clk_sys);
        check("reset ioctl_din", 32'(ioctl_din), 32'h00);
        check("reset ioctl_wait", 32'(ioctl_wait), 32'h0);
        check("reset cpu_pause", 32'(cpu_pause), 32'h0);
        check("reset ram_rd", 32'(ram_rd), 32'h0);
        check("reset ram_addr", 32'(ram_addr), 32'h0);
        check("reset done", 32'(done), 32'h0);
        do_read(25'd0);
        do_read(25'd1);
        @(negedge clk_sys);
        check("idle read wait", 32'(ioctl_wait), 32'h0);
        check("idle read pause", 32'(cpu_pause), 32'h0);

        // Wrong index: block stays idle.
        ioctl_index = 8'd3;
        @(posedge clk_sys); #1 ioctl_upload = 1'b1;
        repeat (3) @(posedge clk_sys);
        do_read(25'd5);
        @(negedge clk_sys);
        check("index3 pause", 32'(cpu_pause), 32'h0);
        check("index3 wait", 32'(ioctl_wait), 32'h0);
        @(posedge clk_sys); #1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd4;

        // Session start outside vblank: request held pending until vblank.
        @(posedge clk_sys); #1 ioctl_upload = 1'b1;
        addr_q.push_back(11'h7F0);
        e.din  = 8'hAA;
        e.done = 1'b0;
        exp_q.push_back(e);
        do_read(25'd0);
        lows = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (!ioctl_wait) lows++;
        end
        check("wait held during sync", 32'(lows), 32'h0);
        check("pause during sync", 32'(cpu_pause), 32'h1);
        @(posedge clk_sys); #1 vblank = 1'b1;
        wait_delivery("first byte");

        // Remaining region: address wrap across 7FF and a single done on 31.
        for (int i = 1; i < 32; i++) begin
            expect_byte(i, i == 31);
            do_read(25'(i));
            wait_delivery("region byte");
        end

        // Out-of-range offsets return the fill byte without touching RAM.
        e.din  = 8'hFF;
        e.done = 1'b0;
        exp_q.push_back(e);
        do_read(25'd40);
        wait_delivery("offset 40");
        exp_q.push_back(e);
        do_read(25'h1000005);
        wait_delivery("high offset");

        // Abort during ISSUE of the last offset: no done, no delivery.
        addr_q.push_back(11'h00F);
        do_read(25'd31);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (!ram_rd && k < 20);
        check("reached issue", 32'(ram_rd), 32'h1);
        #1 ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort pause", 32'(cpu_pause), 32'h0);
        check("abort wait", 32'(ioctl_wait), 32'h0);
        check("abort done", 32'(done), 32'h0);
        check("abort din kept", 32'(ioctl_din), 32'hFF);
        repeat (3) @(negedge clk_sys);

        check("done pulse count", 32'(done_count), 32'd1);
        check("pending data", 32'(exp_q.size()), 32'd0);
        check("pending addresses", 32'(addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
